// File: rtl/darkriscv_bus_arbiter.sv
// ============================================================================
// darkriscv_bus_arbiter
// Shares one single-ported memory between the core fetch and data ports,
// with a one-entry fetch buffer and data-first arbitration.
// Rev 1.0
// ============================================================================
`default_nettype none

module darkriscv_bus_arbiter #(
  parameter int WAITMAX = 15
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IADDR,
  output logic [31:0] IDATA,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [3:0]  BE,
  input  logic        WR,
  input  logic        RD,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        MREQ,
  output logic        MWR,
  output logic [31:0] MADDR,
  output logic [31:0] MDATAO,
  output logic [3:0]  MBE,
  input  logic [31:0] MDATAI,
  input  logic        MACK,
  output logic        BUSERR
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [7:0] C_WAITLAST = 8'(WAITMAX - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_itag;
  logic        r_ival;
  logic        r_dserved;
  logic [7:0]  r_cnt;
  logic [31:0] r_idata;
  logic [31:0] r_datai;
  logic        r_mwr;
  logic [31:0] r_maddr;
  logic [31:0] r_mdatao;
  logic [3:0]  r_mbe;
  logic        r_buserr;

  logic        w_fetch_ok;
  logic        w_data_ok;
  logic        w_hlt;
  logic        w_mreq;
  logic        w_done;
  logic        w_tmo;
  logic        w_start_data;
  logic        w_start_fetch;
  logic [31:0] w_rdata;

  assign w_fetch_ok = r_ival & (r_itag == IADDR);
  assign w_data_ok  = ~(RD | WR) | r_dserved;
  assign w_hlt      = ~(w_fetch_ok & w_data_ok);

  // State register
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: data wins over fetch when both are needed
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_data)       w_next = S_DATA;
        else if (w_start_fetch) w_next = S_FETCH;
      end
      S_DATA, S_FETCH: begin
        if (w_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode from the registered state
  always_comb begin
    w_mreq        = (r_state != S_IDLE);
    w_start_data  = (r_state == S_IDLE) & (RD | WR) & ~r_dserved;
    w_start_fetch = (r_state == S_IDLE) & ~((RD | WR) & ~r_dserved) & ~w_fetch_ok;
    w_tmo         = w_mreq & ~MACK & (r_cnt == C_WAITLAST);
    w_done        = w_mreq & (MACK | (r_cnt == C_WAITLAST));
    w_rdata       = MACK ? MDATAI : 32'h0;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_itag    <= 32'h0;
      r_ival    <= 1'b0;
      r_dserved <= 1'b0;
      r_cnt     <= 8'h0;
      r_idata   <= 32'h0;
      r_datai   <= 32'h0;
      r_mwr     <= 1'b0;
      r_maddr   <= 32'h0;
      r_mdatao  <= 32'h0;
      r_mbe     <= 4'h0;
      r_buserr  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= 8'h0;
        if (w_start_data) begin
          r_maddr  <= DADDR;
          r_mwr    <= WR;
          r_mdatao <= DATAO;
          r_mbe    <= BE;
        end else if (w_start_fetch) begin
          r_maddr <= IADDR;
          r_mwr   <= 1'b0;
          r_mbe   <= 4'hF;
        end
      end else if (!w_done) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_tmo) r_buserr <= 1'b1;

      // The served flag is consumed by the first cycle the core advances
      if ((r_state == S_DATA) && w_done) begin
        if (!r_mwr) r_datai <= w_rdata;
        r_dserved <= 1'b1;
      end else if (!w_hlt) begin
        r_dserved <= 1'b0;
      end

      if ((r_state == S_FETCH) && w_done) begin
        r_idata <= w_rdata;
        r_itag  <= r_maddr;
        r_ival  <= 1'b1;
      end
    end
  end

  assign HLT    = w_hlt;
  assign MREQ   = w_mreq;
  assign MWR    = r_mwr;
  assign MADDR  = r_maddr;
  assign MDATAO = r_mdatao;
  assign MBE    = r_mbe;
  assign IDATA  = r_idata;
  assign DATAI  = r_datai;
  assign BUSERR = r_buserr;

endmodule

`default_nettype wire

// File: tb/tb_darkriscv_bus_arbiter.sv
// ============================================================================
// tb_darkriscv_bus_arbiter
// Directed bench with a transaction-level arbiter model and per-cycle compare.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_darkriscv_bus_arbiter;

  localparam int WM = 4;

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] IADDR, DADDR, DATAO, MDATAI;
  logic [3:0]  BE;
  logic        WR, RD, MACK;
  logic [31:0] IDATA, DATAI, MADDR, MDATAO;
  logic        HLT, MREQ, MWR, BUSERR;
  logic [3:0]  MBE;

  darkriscv_bus_arbiter #(.WAITMAX(WM)) dut (
    .CLK(CLK), .RES(RES), .IADDR(IADDR), .IDATA(IDATA), .DADDR(DADDR),
    .DATAO(DATAO), .BE(BE), .WR(WR), .RD(RD), .DATAI(DATAI), .HLT(HLT),
    .MREQ(MREQ), .MWR(MWR), .MADDR(MADDR), .MDATAO(MDATAO), .MBE(MBE),
    .MDATAI(MDATAI), .MACK(MACK), .BUSERR(BUSERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00000013;
      32'h8:   return 32'h00100093;
      32'h100: return 32'hDEADBEEF;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  // Transaction-level model: at most one memory transaction in flight
  int          m_busy;   // 0 none, 1 data, 2 fetch
  int          m_waits;
  logic [31:0] m_addr, m_wdata, m_tag, m_idata, m_datai;
  logic [3:0]  m_be;
  logic        m_wr, m_val, m_served, m_buserr;
  bit          mf, md, mh, msv;

  function automatic logic exp_hlt();
    return !((m_val && (m_tag == IADDR)) && (!(RD || WR) || m_served));
  endfunction

  always @(posedge CLK or posedge RES) begin
    if (RES) begin
      m_busy = 0; m_waits = 0; m_addr = 0; m_wdata = 0; m_tag = 0;
      m_idata = 0; m_datai = 0; m_be = 0; m_wr = 0; m_val = 0;
      m_served = 0; m_buserr = 0;
    end else begin
      mf  = m_val && (m_tag == IADDR);
      md  = !(RD || WR) || m_served;
      mh  = !(mf && md);
      msv = 0;
      if (m_busy == 0) begin
        if ((RD || WR) && !m_served) begin
          m_busy = 1; m_addr = DADDR; m_wr = WR; m_wdata = DATAO; m_be = BE; m_waits = 0;
        end else if (!mf) begin
          m_busy = 2; m_addr = IADDR; m_wr = 0; m_be = 4'hF; m_waits = 0;
        end
      end else if (MACK || (m_waits == WM - 1)) begin
        if (!MACK) m_buserr = 1;
        if (m_busy == 1) begin
          if (!m_wr) m_datai = MACK ? MDATAI : 32'h0;
          m_served = 1; msv = 1;
        end else begin
          m_idata = MACK ? MDATAI : 32'h0;
          m_tag = m_addr; m_val = 1;
        end
        m_busy = 0;
      end else begin
        m_waits++;
      end
      if (!mh && !msv) m_served = 0;
    end
  end

  // Memory responder driven from the model's view of the bus
  int ack_delay = 0;
  logic stray = 1'b0;
  initial begin MACK = 1'b0; MDATAI = 32'h0; end
  always @(posedge CLK) begin
    #2;
    if (!RES && m_busy != 0 && m_waits == ack_delay) begin
      MACK = 1'b1; MDATAI = memrd(m_addr);
    end else begin
      MACK = stray; MDATAI = 32'hBAD0BAD0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    if (!RES) begin
      check("HLT", {31'h0, HLT}, {31'h0, exp_hlt()});
      check("MREQ", {31'h0, MREQ}, {31'h0, (m_busy != 0)});
      if (m_busy != 0) begin
        check("MADDR", MADDR, m_addr);
        check("MWR", {31'h0, MWR}, {31'h0, m_wr});
        check("MBE", {28'h0, MBE}, {28'h0, m_be});
        if (m_wr) check("MDATAO", MDATAO, m_wdata);
      end
      check("IDATA", IDATA, m_idata);
      check("DATAI", DATAI, m_datai);
      check("BUSERR", {31'h0, BUSERR}, {31'h0, m_buserr});
    end
  end

  // Bus activity monitor
  int   bursts = 0, mreq_cyc = 0;
  logic prev_mreq = 1'b0;
  logic [31:0] last_maddr, last_mdatao;
  logic [3:0]  last_mbe;
  logic        last_mwr;
  always @(negedge CLK) begin
    if (!RES) begin
      if (MREQ && !prev_mreq) bursts++;
      if (MREQ) begin
        mreq_cyc++;
        last_maddr = MADDR; last_mwr = MWR; last_mbe = MBE; last_mdatao = MDATAO;
      end
      prev_mreq = MREQ;
    end else begin
      prev_mreq = 1'b0;
    end
  end

  task automatic go(input logic [31:0] ia, input logic [31:0] da, input logic rd,
                    input logic wr, input logic [31:0] dout, input logic [3:0] be, input int dly);
    @(posedge CLK); #1;
    IADDR = ia; DADDR = da; RD = rd; WR = wr; DATAO = dout; BE = be;
    ack_delay = dly; bursts = 0; mreq_cyc = 0;
  endtask

  task automatic wait_hlt(output int n);
    bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (HLT) n++;
      else seen = 1;
    end
    if (!seen) check("hlt_timeout", 32'h1, 32'h0);
  endtask

  int n;

  initial begin
    RES = 1'b1; IADDR = 0; DADDR = 0; DATAO = 0; BE = 0; RD = 0; WR = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_MREQ", {31'h0, MREQ}, 32'h0);
    check("rst_HLT", {31'h0, HLT}, 32'h1);
    check("rst_MBE", {28'h0, MBE}, 32'h0);

    // First fetch after reset release, zero-wait memory
    @(posedge CLK); #1; RES = 1'b0; bursts = 0; mreq_cyc = 0;
    wait_hlt(n);
    check("t1_hlt_cycles", n, 2);
    check("t1_idata", IDATA, 32'h00000013);
    check("t1_mreq_cycles", mreq_cyc, 1);
    check("t1_mbe", {28'h0, last_mbe}, 32'hF);

    // Hit with nothing to do, plus a stray ack that must be ignored
    go(32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
    stray = 1'b1;
    @(posedge CLK); #1; stray = 1'b0;
    repeat (3) @(negedge CLK);
    check("t1_no_traffic", mreq_cyc, 0);
    check("t1_idata_keep", IDATA, 32'h00000013);

    // Load with three wait cycles
    go(32'h0, 32'h100, 1, 0, 32'h0, 4'hF, 3);
    wait_hlt(n);
    check("t2_hlt_cycles", n, 5);
    check("t2_mreq_cycles", mreq_cyc, 4);
    check("t2_datai", DATAI, 32'hDEADBEEF);

    // Store with partial byte enables
    go(32'h0, 32'h204, 0, 1, 32'h12345678, 4'b0011, 0);
    wait_hlt(n);
    check("t3_hlt_cycles", n, 2);
    check("t3_mwr", {31'h0, last_mwr}, 32'h1);
    check("t3_mdatao", last_mdatao, 32'h12345678);
    check("t3_mbe", {28'h0, last_mbe}, 32'h3);
    check("t3_datai_keep", DATAI, 32'hDEADBEEF);

    // Load and fetch miss together: data first, then fetch
    go(32'h8, 32'h100, 1, 0, 32'h0, 4'hF, 0);
    wait_hlt(n);
    check("t4_hlt_cycles", n, 4);
    check("t4_bursts", bursts, 2);
    check("t4_last_addr", last_maddr, 32'h8);
    check("t4_idata", IDATA, 32'h00100093);

    // RD and WR together act as a write
    go(32'h8, 32'h300, 1, 1, 32'h55AA55AA, 4'hF, 0);
    wait_hlt(n);
    check("t5_rdwr_mwr", {31'h0, last_mwr}, 32'h1);
    check("t5_rdwr_datai", DATAI, 32'hDEADBEEF);

    // Fetch that is never acked times out
    go(32'hC, 32'h0, 0, 0, 32'h0, 4'h0, 255);
    wait_hlt(n);
    check("t6_hlt_cycles", n, 5);
    check("t6_mreq_cycles", mreq_cyc, WM);
    check("t6_idata", IDATA, 32'h0);
    check("t6_buserr", {31'h0, BUSERR}, 32'h1);
    go(32'h10, 32'h0, 0, 0, 32'h0, 4'h0, 0);
    wait_hlt(n);
    check("t6_refetch", IDATA, 32'hA5A5A5B5);
    check("t6_buserr_sticky", {31'h0, BUSERR}, 32'h1);

    // Reset in the second wait cycle of a store
    go(32'h10, 32'h400, 0, 1, 32'hCAFEF00D, 4'hF, 10);
    repeat (3) @(negedge CLK);
    #1; RES = 1'b1;
    #1;
    check("t7_rst_MREQ", {31'h0, MREQ}, 32'h0);
    check("t7_rst_HLT", {31'h0, HLT}, 32'h1);
    check("t7_rst_BUSERR", {31'h0, BUSERR}, 32'h0);
    check("t7_rst_IDATA", IDATA, 32'h0);
    check("t7_rst_DATAI", DATAI, 32'h0);
    ack_delay = 0;
    @(posedge CLK); #1; RES = 1'b0; bursts = 0; mreq_cyc = 0;
    wait_hlt(n);
    check("t7_hlt_cycles", n, 4);
    check("t7_bursts", bursts, 2);
    check("t7_last_addr", last_maddr, 32'h10);
    go(32'h10, 32'h0, 0, 0, 32'h0, 4'h0, 0);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
